// File: rtl/mem_exec_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_exec_unit_pkg                                                  |
// | Shared types for the load/store execute path: queue entry layout,  |
// | memory FSM states, funct3 encodings and an alignment helper.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package mem_exec_unit_pkg;

  localparam int LSQ_ROB_IDX_W = 5;

  // Entry popped from the load/store queue
  typedef struct packed {
    logic                     valid;
    logic                     mem_inst;
    logic                     is_store;
    logic [2:0]               funct3;
    logic [31:0]              rs1_v;
    logic [31:0]              rs2_v;
    logic [31:0]              ls_imm;
    logic [LSQ_ROB_IDX_W-1:0] rob_id_dest;
  } ls_q_entry;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; unknown sizes behave as word accesses
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_exec_unit_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_align                                                         |
// | Byte-lane steering: load extraction/extension, byte masks and      |
// | store data shifted to its lane.                                    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module load_align
  import mem_exec_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] rs2_v_i,
  output logic [31:0] load_data_o,
  output logic [3:0]  byte_mask_o,
  output logic [31:0] wdata_o
);

  logic [31:0] shifted_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;

  assign shifted_d = rdata_i >> {ea_lo_i, 3'b000};
  assign byte_d    = shifted_d[7:0];
  assign half_d    = shifted_d[15:0];
  assign wdata_o   = rs2_v_i << {ea_lo_i, 3'b000};

  // Format the selected lane; anything not byte/half passes the word through
  always_comb begin
    load_data_o = rdata_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_d[7]}}, byte_d};
      F3_LBU:  load_data_o = {24'h0, byte_d};
      F3_LH:   load_data_o = {{16{half_d[15]}}, half_d};
      F3_LHU:  load_data_o = {16'h0, half_d};
      default: load_data_o = rdata_i;
    endcase
  end

  // Lane mask from access size, shared by loads and stores
  always_comb begin
    byte_mask_o = 4'b1111;
    case (funct3_i[1:0])
      2'b00:   byte_mask_o = 4'b0001 << ea_lo_i;
      2'b01:   byte_mask_o = 4'b0011 << ea_lo_i;
      default: byte_mask_o = 4'b1111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_exec_unit                                                      |
// | Consumer end of the load/store queue: one op at a time, computes   |
// | the effective address, runs the data-memory handshake and hands    |
// | the result to writeback.                                           |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mem_exec_unit
  import mem_exec_unit_pkg::*;
#(
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  ls_q_entry            ls_req,
  output logic                 in_flight_mem,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ROB_IDX_W-1:0] wb_rob_id,
  output logic [31:0]          wb_data,
  output logic                 wb_exc
);

  mem_state_t           state_q, state_d;
  logic                 is_store_q, is_store_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [31:0]          rs2_q, rs2_d;
  logic [31:0]          ea_q, ea_d;
  logic [ROB_IDX_W-1:0] rob_q, rob_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 wb_exc_q, wb_exc_d;

  logic [31:0] ea_new;
  logic [31:0] load_fmt;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;

  assign ea_new = ls_req.rs1_v + ls_req.ls_imm;

  load_align u_align (
    .funct3_i    (funct3_q),
    .ea_lo_i     (ea_q[1:0]),
    .rdata_i     (dmem_rdata),
    .rs2_v_i     (rs2_q),
    .load_data_o (load_fmt),
    .byte_mask_o (lane_mask),
    .wdata_o     (lane_wdata)
  );

  // State and transaction registers; reset drops any transaction in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      rs2_q      <= 32'h0;
      ea_q       <= 32'h0;
      rob_q      <= '0;
      wb_data_q  <= 32'h0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      rs2_q      <= rs2_d;
      ea_q       <= ea_d;
      rob_q      <= rob_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  // Next state, capture of the accepted op/response, and memory strobes
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    rs2_d      = rs2_q;
    ea_d       = ea_q;
    rob_d      = rob_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    dmem_rmask = 4'b0000;
    dmem_wmask = 4'b0000;
    dmem_wdata = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (ls_req.valid && ls_req.mem_inst) begin
          is_store_d = ls_req.is_store;
          funct3_d   = ls_req.funct3;
          rs2_d      = ls_req.rs2_v;
          ea_d       = ea_new;
          rob_d      = ROB_IDX_W'(ls_req.rob_id_dest);
          wb_data_d  = 32'h0;
          wb_exc_d   = is_misaligned(ls_req.funct3, ea_new[1:0]);
          // Misaligned ops skip memory and report the exception directly
          state_d    = wb_exc_d ? WB : REQ;
        end
      end
      REQ: begin
        if (is_store_q) begin
          dmem_wmask = lane_mask;
          dmem_wdata = lane_wdata;
        end else begin
          dmem_rmask = lane_mask;
        end
        if (dmem_resp) begin
          wb_data_d = is_store_q ? 32'h0 : load_fmt;
          state_d   = WB;
        end else begin
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          wb_data_d = is_store_q ? 32'h0 : load_fmt;
          state_d   = WB;
        end
      end
      WB: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_flight_mem = (state_q != IDLE);
  assign dmem_addr     = {ea_q[31:2], 2'b00};
  assign wb_valid      = (state_q == WB);
  assign wb_rob_id     = rob_q;
  assign wb_data       = wb_data_q;
  assign wb_exc        = wb_exc_q;

endmodule
`default_nettype wire
